// File: rtl/pool_layer.sv
// Streaming 2x2 stride-2 signed max-pool over one feature map, with a half-row line buffer.
// Optional build macro POOL_RELU_CLAMP_EN clamps negative input pixels to zero before use.
module pool_layer #(
    parameter int POOL_X          = 24,
    parameter int POOL_Y          = 24,
    parameter int POOL_DATA_WIDTH = 45
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       pool_enable,
    input  logic                       relu_valid,
    input  logic [POOL_DATA_WIDTH-1:0] relu_data,
    output logic                       relu_ready,
    output logic                       pool_valid,
    output logic [POOL_DATA_WIDTH-1:0] pool_data,
    input  logic                       pool_ready,
    output logic                       pool_done
);

    localparam int W   = POOL_DATA_WIDTH;
    localparam int LBD = POOL_X / 2;
    localparam int LBW = (LBD > 1) ? $clog2(LBD) : 1;
    localparam int CW  = LBW + 1;
    localparam int RW  = (POOL_Y > 2) ? $clog2(POOL_Y) : 1;

    localparam logic [CW-1:0] COL_LAST = CW'(POOL_X - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(POOL_Y - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]    state;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [W-1:0]  h;
    logic [W-1:0]  lb [LBD];
    logic [W-1:0]  pix;
    logic [LBW-1:0] lb_idx;
    logic          accept;
    logic          out_hs;
    logic          col_last;
    logic          row_last;

    function automatic logic [W-1:0] smax(input logic [W-1:0] a, input logic [W-1:0] b);
        return ($signed(a) > $signed(b)) ? a : b;
    endfunction

    assign relu_ready = (state == S_RUN) && (!pool_valid || pool_ready);
    assign accept     = relu_valid && relu_ready;
    assign out_hs     = pool_valid && pool_ready;
    assign col_last   = (col == COL_LAST);
    assign row_last   = (row == ROW_LAST);
    assign lb_idx     = col[CW-1:1];

    // Input pixel conditioning (optional clamp of negatives)
    always_comb begin
        pix = relu_data;
`ifdef POOL_RELU_CLAMP_EN
        if (relu_data[W-1]) begin
            pix = {W{1'b0}};
        end else begin
            pix = relu_data;
        end
`endif
    end

    // Control FSM, raster counters, hold register and output register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            col        <= {CW{1'b0}};
            row        <= {RW{1'b0}};
            h          <= {W{1'b0}};
            pool_data  <= {W{1'b0}};
            pool_valid <= 1'b0;
            pool_done  <= 1'b0;
        end else begin
            pool_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (pool_enable) begin
                        state      <= S_RUN;
                        col        <= {CW{1'b0}};
                        row        <= {RW{1'b0}};
                        pool_data  <= {W{1'b0}};
                        pool_valid <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (!pool_enable) begin
                        state      <= S_IDLE;
                        pool_valid <= 1'b0;
                    end else begin
                        if (out_hs) begin
                            pool_valid <= 1'b0;
                        end
                        if (accept) begin
                            if (col_last) begin
                                col <= {CW{1'b0}};
                                row <= row_last ? {RW{1'b0}} : row + {{(RW-1){1'b0}}, 1'b1};
                            end else begin
                                col <= col + {{(CW-1){1'b0}}, 1'b1};
                            end
                            // Bottom-right pixel closes a window; a same-cycle handshake is overridden
                            if (row[0] && col[0]) begin
                                pool_data  <= smax(lb[lb_idx], smax(h, pix));
                                pool_valid <= 1'b1;
                            end else if (!col[0]) begin
                                h <= pix;
                            end
                            if (row_last && col_last) begin
                                state <= S_DRAIN;
                            end
                        end
                    end
                end
                S_DRAIN: begin
                    if (!pool_enable) begin
                        state      <= S_IDLE;
                        pool_valid <= 1'b0;
                    end else if (out_hs) begin
                        state      <= S_DONE;
                        pool_valid <= 1'b0;
                        pool_done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state      <= S_IDLE;
                    pool_valid <= 1'b0;
                end
            endcase
        end
    end

    // Half-row line buffer: top-row pair maxima, always written before being read
    always_ff @(posedge clk) begin
        if (state == S_RUN && pool_enable && accept && !row[0] && col[0]) begin
            lb[lb_idx] <= smax(h, pix);
        end
    end

endmodule
